// File: rtl/tnn_pkg.sv
// Shared types and width/weight helpers for the serial ternary classifier.
package tnn_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    ARG  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic int acc1_bits(input int feat_bits, input int feat_cnt);
    return feat_bits + $clog2(feat_cnt + 1) + 1;
  endfunction

  function automatic int score_bits(input int hidden_cnt);
    return $clog2(hidden_cnt + 1) + 1;
  endfunction

  // POS and NEG both set is a zero weight, same as neither set.
  function automatic logic signed [31:0] ternary_sel(input logic pos, input logic neg,
                                                     input logic signed [31:0] val);
    logic signed [31:0] res;
    if (pos && !neg) begin
      res = val;
    end else if (neg && !pos) begin
      res = -val;
    end else begin
      res = 32'sd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/tnn_seq_classifier_if.sv
// Feature-in / prediction-out handshake bundle of the classifier.
interface tnn_seq_classifier_if #(
  parameter int FEAT_CNT  = 12,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6
);
  localparam int PRED_BITS = $clog2(CLASS_CNT);

  logic [FEAT_BITS*FEAT_CNT-1:0] data;
  logic                          in_valid;
  logic                          in_ready;
  logic [PRED_BITS-1:0]          prediction;
  logic                          out_valid;
  logic                          out_ready;

  modport master (output data, in_valid, out_ready,
                  input  in_ready, prediction, out_valid);
  modport slave  (input  data, in_valid, out_ready,
                  output in_ready, prediction, out_valid);
endinterface

// File: rtl/tnn_acc_bank.sv
// Bank of N signed accumulators; each lane adds +op, -op or 0 of one shared operand.
module tnn_acc_bank
  import tnn_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [N-1:0]        pos_i,
  input  logic [N-1:0]        neg_i,
  input  logic signed [W-1:0] operand_i,
  output logic [N*W-1:0]      acc_o
);

  logic signed [W-1:0] acc_q [N];
  logic signed [W-1:0] acc_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_d[i] = acc_q[i];
      if (clr_i) begin
        acc_d[i] = {W{1'b0}};
      end else if (en_i) begin
        acc_d[i] = acc_q[i] + W'(ternary_sel(pos_i[i], neg_i[i],
                                             {{(32-W){operand_i[W-1]}}, operand_i}));
      end else begin
        acc_d[i] = acc_q[i];
      end
      acc_o[i*W +: W] = acc_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) acc_q[i] <= {W{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule

// File: rtl/tnn_seq_classifier.sv
// Serial two-layer ternary NN: one feature per cycle, one hidden neuron per cycle,
// then a sequential argmax; the prediction is held until the consumer takes it.
module tnn_seq_classifier
  import tnn_pkg::*;
#(
  parameter int FEAT_CNT   = 12,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_POS = {(FEAT_CNT*HIDDEN_CNT){1'b0}},
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_NEG = {(FEAT_CNT*HIDDEN_CNT){1'b0}},
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_POS = {(HIDDEN_CNT*CLASS_CNT){1'b0}},
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_NEG = {(HIDDEN_CNT*CLASS_CNT){1'b0}}
) (
  input logic                clk,
  input logic                rst,
  tnn_seq_classifier_if.slave bus
);

  localparam int A1W       = acc1_bits(FEAT_BITS, FEAT_CNT);
  localparam int SW        = score_bits(HIDDEN_CNT);
  localparam int PRED_BITS = $clog2(CLASS_CNT);
  localparam int MAXC      = (FEAT_CNT > HIDDEN_CNT) ?
                             ((FEAT_CNT > CLASS_CNT) ? FEAT_CNT : CLASS_CNT) :
                             ((HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT);
  localparam int CW        = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [FEAT_BITS*FEAT_CNT-1:0] data_q, data_d;
  logic signed [SW-1:0]          best_val_q, best_val_d;
  logic [PRED_BITS-1:0]          best_idx_q, best_idx_d;
  logic [PRED_BITS-1:0]          pred_q, pred_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;

  logic                          acc1_clr_s, acc1_en_s, score_clr_s, score_en_s;
  logic [HIDDEN_CNT-1:0]         w1p_s, w1n_s;
  logic [CLASS_CNT-1:0]          w2p_s, w2n_s;
  logic [FEAT_BITS-1:0]          feat_s;
  logic signed [A1W-1:0]         x_op_s;
  logic signed [SW-1:0]          h_op_s;
  logic signed [SW-1:0]          cur_score_s;
  logic [HIDDEN_CNT*A1W-1:0]     acc1_s;
  logic [CLASS_CNT*SW-1:0]       score_s;

  tnn_acc_bank #(.N(HIDDEN_CNT), .W(A1W)) u_acc1 (
    .clk(clk), .rst(rst), .clr_i(acc1_clr_s), .en_i(acc1_en_s),
    .pos_i(w1p_s), .neg_i(w1n_s), .operand_i(x_op_s), .acc_o(acc1_s)
  );

  tnn_acc_bank #(.N(CLASS_CNT), .W(SW)) u_score (
    .clk(clk), .rst(rst), .clr_i(score_clr_s), .en_i(score_en_s),
    .pos_i(w2p_s), .neg_i(w2n_s), .operand_i(h_op_s), .acc_o(score_s)
  );

  // Next-state, counter, datapath steering and argmax tracking.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    pred_d      = pred_q;
    acc1_clr_s  = 1'b0;
    acc1_en_s   = 1'b0;
    score_clr_s = 1'b0;
    score_en_s  = 1'b0;
    w1p_s       = {HIDDEN_CNT{1'b0}};
    w1n_s       = {HIDDEN_CNT{1'b0}};
    w2p_s       = {CLASS_CNT{1'b0}};
    w2n_s       = {CLASS_CNT{1'b0}};
    feat_s      = {FEAT_BITS{1'b0}};
    h_op_s      = {SW{1'b0}};
    cur_score_s = {SW{1'b0}};
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d      = bus.data;
          acc1_clr_s  = 1'b1;
          score_clr_s = 1'b1;
          cnt_d       = {CW{1'b0}};
          state_d     = L1;
        end else begin
          state_d = IDLE;
        end
      end
      L1: begin
        acc1_en_s = 1'b1;
        feat_s    = data_q[int'(cnt_q)*FEAT_BITS +: FEAT_BITS];
        w1p_s     = W1_POS[int'(cnt_q)*HIDDEN_CNT +: HIDDEN_CNT];
        w1n_s     = W1_NEG[int'(cnt_q)*HIDDEN_CNT +: HIDDEN_CNT];
        if (cnt_q == CW'(FEAT_CNT - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = L2;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      L2: begin
        score_en_s = 1'b1;
        w2p_s      = W2_POS[int'(cnt_q)*CLASS_CNT +: CLASS_CNT];
        w2n_s      = W2_NEG[int'(cnt_q)*CLASS_CNT +: CLASS_CNT];
        // A zero accumulator binarises to +1.
        if (acc1_s[int'(cnt_q)*A1W + A1W - 1]) begin
          h_op_s = {SW{1'b1}};
        end else begin
          h_op_s = {{(SW-1){1'b0}}, 1'b1};
        end
        if (cnt_q == CW'(HIDDEN_CNT - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = ARG;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ARG: begin
        cur_score_s = score_s[int'(cnt_q)*SW +: SW];
        if ((cnt_q == {CW{1'b0}}) || (cur_score_s > best_val_q)) begin
          best_val_d = cur_score_s;
          best_idx_d = PRED_BITS'(cnt_q);
        end else begin
          best_val_d = best_val_q;
        end
        if (cnt_q == CW'(CLASS_CNT - 1)) begin
          cnt_d   = {CW{1'b0}};
          pred_d  = best_idx_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign x_op_s = {{(A1W-FEAT_BITS){1'b0}}, feat_s};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      data_q      <= {(FEAT_BITS*FEAT_CNT){1'b0}};
      best_val_q  <= {SW{1'b0}};
      best_idx_q  <= {PRED_BITS{1'b0}};
      pred_q      <= {PRED_BITS{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      pred_q      <= pred_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.prediction = pred_q;

endmodule

// File: tb/tb_tnn_seq_classifier.sv
// Directed and randomised checks of tnn_seq_classifier against an arithmetic model.
module tb_tnn_seq_classifier;

  localparam int FA = 2, HA = 2, CA = 3, FBA = 4;
  localparam logic [3:0] W1PA = 4'b1001;
  localparam logic [3:0] W1NA = 4'b0110;
  localparam logic [5:0] W2PA = 6'b010101;
  localparam logic [5:0] W2NA = 6'b000100;

  localparam int FB = 5, HB = 6, CB = 4, FBB = 3;
  localparam logic [29:0] W1PB = 30'h2A5C_3391;
  localparam logic [29:0] W1NB = 30'h1593_6C4E;
  localparam logic [23:0] W2PB = 24'hC3_5A96;
  localparam logic [23:0] W2NB = 24'h3C_E56D;

  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tnn_seq_classifier_if #(.FEAT_CNT(FA), .FEAT_BITS(FBA), .CLASS_CNT(CA)) bus_a ();
  tnn_seq_classifier_if #(.FEAT_CNT(FB), .FEAT_BITS(FBB), .CLASS_CNT(CB)) bus_b ();

  tnn_seq_classifier #(.FEAT_CNT(FA), .FEAT_BITS(FBA), .HIDDEN_CNT(HA), .CLASS_CNT(CA),
                       .W1_POS(W1PA), .W1_NEG(W1NA), .W2_POS(W2PA), .W2_NEG(W2NA))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  tnn_seq_classifier #(.FEAT_CNT(FB), .FEAT_BITS(FBB), .HIDDEN_CNT(HB), .CLASS_CNT(CB),
                       .W1_POS(W1PB), .W1_NEG(W1NB), .W2_POS(W2PB), .W2_NEG(W2NB))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    logic [31:0] e;
    e = exp;
    ncmp++;
    assert (obs === e) else begin
      nfail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wt(input logic p, input logic n);
    if (p && !n) return 1;
    if (n && !p) return -1;
    return 0;
  endfunction

  // Reference: dot products, sign binarisation, lowest-index argmax.
  function automatic int model(input int fc, input int hc, input int cc, input int fb,
                               input logic [63:0] w1p, input logic [63:0] w1n,
                               input logic [63:0] w2p, input logic [63:0] w2n,
                               input logic [63:0] d);
    int hid[64];
    int sc[16];
    int best;
    for (int h = 0; h < hc; h++) begin
      int a = 0;
      for (int f = 0; f < fc; f++) begin
        int x = int'((d >> (f*fb)) & ((64'd1 << fb) - 64'd1));
        a += x * wt(w1p[f*hc+h], w1n[f*hc+h]);
      end
      hid[h] = (a >= 0) ? 1 : -1;
    end
    for (int c = 0; c < cc; c++) begin
      sc[c] = 0;
      for (int h = 0; h < hc; h++) sc[c] += hid[h] * wt(w2p[h*cc+c], w2n[h*cc+c]);
    end
    best = 0;
    for (int c = 1; c < cc; c++) if (sc[c] > sc[best]) best = c;
    return best;
  endfunction

  function automatic int model_a(input int x0, input int x1);
    logic [63:0] d;
    d = (64'(x1) << 4) | 64'(x0);
    return model(FA, HA, CA, FBA, 64'(W1PA), 64'(W1NA), 64'(W2PA), 64'(W2NA), d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One inference on dut_a; garbage held on data/in_valid while busy must be ignored.
  task automatic run_a(input int x0, input int x1, input int exp_pred, input string tag);
    int n;
    logic [3:0] a0, a1;
    a0 = x0[3:0];
    a1 = x1[3:0];
    bus_a.data = {a1, a0};
    bus_a.in_valid = 1'b1;
    n = 0;
    while (!bus_a.in_ready && n < 50) begin step(); n++; end
    check({tag, "_ready"}, 32'(bus_a.in_ready), 1);
    step();
    bus_a.data = {a0, a1};
    check({tag, "_busy"}, 32'(bus_a.in_ready), 0);
    n = 0;
    while (!bus_a.out_valid && n < 50) begin step(); n++; end
    bus_a.in_valid = 1'b0;
    check({tag, "_latency"}, 32'(n), FA + HA + CA);
    check({tag, "_pred"}, 32'(bus_a.prediction), exp_pred);
  endtask

  logic [14:0] vec_b [12];

  initial begin
    int n, seen, prev, acc_cyc;
    rst = 1'b0;
    bus_a.data = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.data = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    step(); step();
    check("rst_in_ready", 32'(bus_a.in_ready), 0);
    check("rst_out_valid", 32'(bus_a.out_valid), 0);
    check("rst_pred", 32'(bus_a.prediction), 0);
    rst = 1'b1;
    step();
    check("rel_in_ready", 32'(bus_a.in_ready), 1);

    run_a(5, 3, 0, "s1");
    step();
    check("s1_xfer_ov", 32'(bus_a.out_valid), 0);
    check("s1_xfer_ir", 32'(bus_a.in_ready), 1);
    run_a(3, 5, 1, "s2");
    step();
    run_a(4, 4, 0, "s3");
    step();

    bus_a.out_ready = 1'b0;
    run_a(3, 5, 1, "s4");
    for (int i = 0; i < 10; i++) begin
      step();
      check("s4_hold_ov", 32'(bus_a.out_valid), 1);
      check("s4_hold_pred", 32'(bus_a.prediction), 1);
      check("s4_hold_ir", 32'(bus_a.in_ready), 0);
    end
    bus_a.out_ready = 1'b1;
    step();
    check("s4_xfer_ov", 32'(bus_a.out_valid), 0);
    check("s4_xfer_ir", 32'(bus_a.in_ready), 1);

    bus_a.data = {4'd5, 4'd3};
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("s5_rst_ov", 32'(bus_a.out_valid), 0);
    check("s5_rst_pred", 32'(bus_a.prediction), 0);
    check("s5_rst_ir", 32'(bus_a.in_ready), 0);
    rst = 1'b1;
    step();
    check("s5_rel_ir", 32'(bus_a.in_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_a.out_valid) seen++;
    end
    check("s5_aborted", 32'(seen), 0);
    run_a(5, 3, 0, "s5_after");
    step();

    for (int i = 0; i < 16; i++) begin
      int x0, x1;
      x0 = int'($urandom_range(0, 15));
      x1 = int'($urandom_range(0, 15));
      run_a(x0, x1, model_a(x0, x1), "rand_a");
      step();
    end

    for (int i = 0; i < 12; i++) vec_b[i] = 15'($urandom);
    bus_b.data = vec_b[0];
    bus_b.in_valid = 1'b1;
    n = 0;
    while (!bus_b.in_ready && n < 50) begin step(); n++; end
    check("b_ready", 32'(bus_b.in_ready), 1);
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      acc_cyc = cyc;
      if (i > 0) check("b_throughput", 32'(acc_cyc - prev), FB + HB + CB + 2);
      prev = acc_cyc;
      if (i < 11) begin
        bus_b.data = vec_b[i+1];
      end else begin
        bus_b.data = 15'($urandom);
        bus_b.in_valid = 1'b0;
      end
      n = 0;
      while (!bus_b.out_valid && n < 100) begin step(); n++; end
      check("b_latency", 32'(n), FB + HB + CB);
      check("b_pred", 32'(bus_b.prediction),
            model(FB, HB, CB, FBB, 64'(W1PB), 64'(W1NB), 64'(W2PB), 64'(W2NB), 64'(vec_b[i])));
      step();
      check("b_xfer_ov", 32'(bus_b.out_valid), 0);
      check("b_xfer_ir", 32'(bus_b.in_ready), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
